flb_dec: RTL and testbench

- Receiving-end decoder for the FLB DCO control interface.
- Takes the 64-bit matrix thermometer bus and the 3-bit oversampling thermometer, checks that the code is legal, and converts it back to a binary unit-cell count on every nsh_clk cycle.
- Accumulates the count over each reference window (delimited by ref_tick) and publishes sum, sample count, error count and optional min/max.
- Used as the DCO-side tuning-word model and as a checker in FLB-level benches.

---
 rtl/flb_dec.sv | 199 +++++++++++++++++++
 tb/tb_flb_dec.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flb_dec.sv
// rtl/flb_dec.sv - FLB DCO thermometer decoder with per-reference-window accumulation
// Optional min/max tracking is enabled by defining FLB_DEC_MINMAX_EN.
module flb_dec #(
    parameter int CNT_W = 12,
    parameter int SUM_W = 21,
    parameter int ERR_W = 8
) (
    input  logic             nsh_clk,
    input  logic             rst,
    input  logic             ref_tick,
    input  logic [63:0]      mtrx_thrm,
    input  logic [2:0]       os_thrm,
    output logic [8:0]       inst_code,
    output logic             inst_vld,
    output logic             res_vld,
    output logic [SUM_W-1:0] res_sum,
    output logic [CNT_W-1:0] res_cnt,
    output logic [ERR_W-1:0] res_err_cnt,
    output logic             res_ovf,
    output logic [8:0]       code_min,
    output logic [8:0]       code_max,
    output logic             err_sticky
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [63:0]      mtrx_q;
    logic [2:0]       os_q;
    logic             tick1_q, full1_q;

    logic [15:0]      row_p, row_n, col_on, col_off;
    logic [4:0]       p_cnt, c_cnt;
    logic [1:0]       o_cnt;
    logic             legal;
    logic [8:0]       code;

    logic [8:0]       code2_q;
    logic             vld2_q, bad2_q, tick2_q;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d, b_sum, res_sum_q, res_sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, b_cnt, res_cnt_q, res_cnt_d;
    logic [ERR_W-1:0] err_q, err_d, b_err, res_err_q, res_err_d;
    logic             res_vld_q, res_vld_d, res_ovf_q, res_ovf_d;
    logic             sticky_q, sticky_d;

    assign row_p   = mtrx_q[63:48];
    assign row_n   = mtrx_q[47:32];
    assign col_on  = mtrx_q[31:16];
    assign col_off = mtrx_q[15:0];
    assign p_cnt   = 5'($countones(row_p));
    assign c_cnt   = 5'($countones(col_on));
    assign o_cnt   = 2'($countones(os_q));
    assign code    = {p_cnt, 4'b0000} + 9'(c_cnt) + 9'(o_cnt);

    // x & (x+1) == 0 is the LSB-contiguous test; once row_p is a thermometer,
    // the expected one-hot row_n is simply row_p + 1 (wrapping to 0 at full scale).
    always_comb begin
        legal = ((row_p & (row_p + 16'd1)) == 16'd0)
             && (row_n == row_p + 16'd1)
             && ((col_on & (col_on + 16'd1)) == 16'd0)
             && (col_off == ~col_on)
             && (!row_p[15] || (col_on == 16'd0))
             && ((os_q & (os_q + 3'd1)) == 3'd0);
    end

`ifdef FLB_DEC_MINMAX_EN
    logic [8:0] min_q, min_d, b_min, res_min_q, res_min_d;
    logic [8:0] max_q, max_d, b_max, res_max_q, res_max_d;
    assign code_min = res_min_q;
    assign code_max = res_max_q;
`else
    assign code_min = 9'd0;
    assign code_max = 9'd0;
`endif

    // The sample that travels with a tick opens the new window, so the
    // accumulation base is a fresh window whenever the tick is present.
    always_comb begin
        b_sum     = tick2_q ? '0 : sum_q;
        b_cnt     = tick2_q ? '0 : cnt_q;
        b_err     = tick2_q ? '0 : err_q;
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        res_vld_d = 1'b0;
        res_sum_d = res_sum_q;
        res_cnt_d = res_cnt_q;
        res_err_d = res_err_q;
        res_ovf_d = res_ovf_q;
        sticky_d  = sticky_q | bad2_q;
`ifdef FLB_DEC_MINMAX_EN
        b_min     = tick2_q ? 9'd511 : min_q;
        b_max     = tick2_q ? 9'd0 : max_q;
        min_d     = min_q;
        max_d     = max_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
`endif
        if (state_q == ACCUM || tick2_q) begin
            state_d = ACCUM;
            sum_d   = b_sum;
            cnt_d   = b_cnt;
            err_d   = b_err;
`ifdef FLB_DEC_MINMAX_EN
            min_d   = b_min;
            max_d   = b_max;
`endif
            if (vld2_q && (b_cnt != CNT_MAX)) begin
                sum_d = b_sum + SUM_W'(code2_q);
                cnt_d = b_cnt + CNT_W'(1);
`ifdef FLB_DEC_MINMAX_EN
                if (code2_q < b_min) min_d = code2_q;
                if (code2_q > b_max) max_d = code2_q;
`endif
            end
            if (bad2_q && (b_err != ERR_MAX)) begin
                err_d = b_err + ERR_W'(1);
            end
        end
        if (state_q == ACCUM && tick2_q) begin
            res_vld_d = 1'b1;
            res_sum_d = sum_q;
            res_cnt_d = cnt_q;
            res_err_d = err_q;
            res_ovf_d = (cnt_q == CNT_MAX) || (err_q == ERR_MAX);
`ifdef FLB_DEC_MINMAX_EN
            res_min_d = (cnt_q == '0) ? 9'd0 : min_q;
            res_max_d = (cnt_q == '0) ? 9'd0 : max_q;
`endif
        end
    end

    always_ff @(posedge nsh_clk) begin
        if (rst) begin
            mtrx_q    <= '0;
            os_q      <= '0;
            tick1_q   <= 1'b0;
            full1_q   <= 1'b0;
            code2_q   <= '0;
            vld2_q    <= 1'b0;
            bad2_q    <= 1'b0;
            tick2_q   <= 1'b0;
            state_q   <= IDLE;
            sum_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            res_vld_q <= 1'b0;
            res_sum_q <= '0;
            res_cnt_q <= '0;
            res_err_q <= '0;
            res_ovf_q <= 1'b0;
            sticky_q  <= 1'b0;
`ifdef FLB_DEC_MINMAX_EN
            min_q     <= '0;
            max_q     <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
`endif
        end else begin
            mtrx_q    <= mtrx_thrm;
            os_q      <= os_thrm;
            tick1_q   <= ref_tick;
            full1_q   <= 1'b1;
            code2_q   <= (legal && full1_q) ? code : 9'd0;
            vld2_q    <= legal && full1_q;
            bad2_q    <= !legal && full1_q;
            tick2_q   <= tick1_q;
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            res_vld_q <= res_vld_d;
            res_sum_q <= res_sum_d;
            res_cnt_q <= res_cnt_d;
            res_err_q <= res_err_d;
            res_ovf_q <= res_ovf_d;
            sticky_q  <= sticky_d;
`ifdef FLB_DEC_MINMAX_EN
            min_q     <= min_d;
            max_q     <= max_d;
            res_min_q <= res_min_d;
            res_max_q <= res_max_d;
`endif
        end
    end

    assign inst_code   = code2_q;
    assign inst_vld    = vld2_q;
    assign res_vld     = res_vld_q;
    assign res_sum     = res_sum_q;
    assign res_cnt     = res_cnt_q;
    assign res_err_cnt = res_err_q;
    assign res_ovf     = res_ovf_q;
    assign err_sticky  = sticky_q;
endmodule

// File: tb/tb_flb_dec.sv
// tb/tb_flb_dec.sv - scoreboard bench for flb_dec (default widths and a CNT_W=4/ERR_W=4 instance)
module tb_flb_dec;
    logic        nsh_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ref_tick = 1'b0;
    logic [63:0] mtrx_thrm = '0;
    logic [2:0]  os_thrm = '0;

    logic [8:0]  inst_code_a, code_min_a, code_max_a;
    logic        inst_vld_a, res_vld_a, res_ovf_a, err_sticky_a;
    logic [20:0] res_sum_a;
    logic [11:0] res_cnt_a;
    logic [7:0]  res_err_a;

    logic [8:0]  inst_code_b, code_min_b, code_max_b;
    logic        inst_vld_b, res_vld_b, res_ovf_b, err_sticky_b;
    logic [20:0] res_sum_b;
    logic [3:0]  res_cnt_b;
    logic [3:0]  res_err_b;

    flb_dec dut_a (
        .nsh_clk(nsh_clk), .rst(rst), .ref_tick(ref_tick), .mtrx_thrm(mtrx_thrm), .os_thrm(os_thrm),
        .inst_code(inst_code_a), .inst_vld(inst_vld_a), .res_vld(res_vld_a), .res_sum(res_sum_a),
        .res_cnt(res_cnt_a), .res_err_cnt(res_err_a), .res_ovf(res_ovf_a),
        .code_min(code_min_a), .code_max(code_max_a), .err_sticky(err_sticky_a)
    );

    flb_dec #(.CNT_W(4), .SUM_W(21), .ERR_W(4)) dut_b (
        .nsh_clk(nsh_clk), .rst(rst), .ref_tick(ref_tick), .mtrx_thrm(mtrx_thrm), .os_thrm(os_thrm),
        .inst_code(inst_code_b), .inst_vld(inst_vld_b), .res_vld(res_vld_b), .res_sum(res_sum_b),
        .res_cnt(res_cnt_b), .res_err_cnt(res_err_b), .res_ovf(res_ovf_b),
        .code_min(code_min_b), .code_max(code_max_b), .err_sticky(err_sticky_b)
    );

    always #5 nsh_clk = ~nsh_clk;

    typedef struct {
        logic [15:0] rp, rn, con, coff;
        logic [2:0]  os;
        int          code;
        logic        vld;
    } vec_t;

    typedef struct {
        int   due;
        int   sum;
        int   cnt;
        int   err;
        logic ovf;
        int   mn;
        int   mx;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    int   sticky_chk = -1;
    exp_t sbq0[$];
    exp_t sbq1[$];

    int   hist_code[2];
    logic hist_vld[2];
    bit   in_win = 0;
    int   m_sum[2], m_cnt[2], m_err[2], m_min[2], m_max[2];
    int   cmax[2] = '{4095, 15};
    int   emax[2] = '{255, 15};

    vec_t tbl[12];
    vec_t V54, VBAD;

    always @(posedge nsh_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_res(input int idx, input logic vld, input logic [31:0] sum, input logic [31:0] cnt,
                           input logic [31:0] err, input logic ovf, input logic [31:0] mn, input logic [31:0] mx);
        exp_t e;
        bit   have;
        have = 0;
        if (idx == 0 && sbq0.size() > 0 && sbq0[0].due <= cyc) begin e = sbq0.pop_front(); have = 1; end
        if (idx == 1 && sbq1.size() > 0 && sbq1[0].due <= cyc) begin e = sbq1.pop_front(); have = 1; end
        if (have) begin
            chk($sformatf("res_vld[%0d]", idx), {31'd0, vld}, 1);
            if (e.due == cyc) begin
                chk($sformatf("res_sum[%0d]", idx), sum, e.sum);
                chk($sformatf("res_cnt[%0d]", idx), cnt, e.cnt);
                chk($sformatf("res_err_cnt[%0d]", idx), err, e.err);
                chk($sformatf("res_ovf[%0d]", idx), {31'd0, ovf}, {31'd0, e.ovf});
                chk($sformatf("code_min[%0d]", idx), mn, e.mn);
                chk($sformatf("code_max[%0d]", idx), mx, e.mx);
            end
        end else if (vld !== 1'b0) begin
            chk($sformatf("res_vld_unexpected[%0d]", idx), {31'd0, vld}, 0);
        end
    endtask

    always @(negedge nsh_clk) begin
        if (mon_en) begin
            chk_res(0, res_vld_a, res_sum_a, res_cnt_a, res_err_a, res_ovf_a, code_min_a, code_max_a);
            chk_res(1, res_vld_b, res_sum_b, res_cnt_b, res_err_b, res_ovf_b, code_min_b, code_max_b);
        end
    end

    task automatic push_window();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.due = cyc + 3;
            e.sum = m_sum[d];
            e.cnt = m_cnt[d];
            e.err = m_err[d];
            e.ovf = (m_cnt[d] == cmax[d]) || (m_err[d] == emax[d]);
`ifdef FLB_DEC_MINMAX_EN
            e.mn = (m_cnt[d] == 0) ? 0 : m_min[d];
            e.mx = (m_cnt[d] == 0) ? 0 : m_max[d];
`else
            e.mn = 0;
            e.mx = 0;
`endif
            if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
        end
    endtask

    task automatic model_sample(input vec_t v, input logic tick);
        if (tick) begin
            if (in_win) push_window();
            in_win = 1;
            for (int d = 0; d < 2; d++) begin
                m_sum[d] = 0; m_cnt[d] = 0; m_err[d] = 0; m_min[d] = 511; m_max[d] = 0;
            end
        end
        if (in_win) begin
            for (int d = 0; d < 2; d++) begin
                if (v.vld) begin
                    if (m_cnt[d] < cmax[d]) begin
                        m_cnt[d]++;
                        m_sum[d] += v.code;
                        if (v.code < m_min[d]) m_min[d] = v.code;
                        if (v.code > m_max[d]) m_max[d] = v.code;
                    end
                end else if (m_err[d] < emax[d]) begin
                    m_err[d]++;
                end
            end
        end
    endtask

    task automatic step(input vec_t v, input logic tick);
        ref_tick  = tick;
        mtrx_thrm = {v.rp, v.rn, v.con, v.coff};
        os_thrm   = v.os;
        model_sample(v, tick);
        @(negedge nsh_clk);
        chk("inst_code", inst_code_a, hist_code[1]);
        chk("inst_vld", {31'd0, inst_vld_a}, {31'd0, hist_vld[1]});
        chk("inst_code_b", inst_code_b, hist_code[1]);
        if (sticky_chk >= 0) begin
            chk("err_sticky", {31'd0, err_sticky_a}, sticky_chk);
            sticky_chk = -1;
        end
        hist_code[1] = hist_code[0];
        hist_vld[1]  = hist_vld[0];
        hist_code[0] = v.code;
        hist_vld[0]  = v.vld;
        @(posedge nsh_clk);
        #1;
    endtask

    task automatic run_window(input vec_t v, input int n, input int bad_start, input int bad_len);
        for (int i = 0; i < n; i++)
            step((i >= bad_start && i < bad_start + bad_len) ? VBAD : v, i == 0);
    endtask

    task automatic do_reset(input int n);
        sbq0.delete();
        sbq1.delete();
        in_win = 0;
        for (int i = 0; i < n; i++) begin
            rst       = 1'b1;
            ref_tick  = 1'($urandom_range(0, 1));
            mtrx_thrm = {$urandom, $urandom};
            os_thrm   = 3'($urandom_range(0, 7));
            @(posedge nsh_clk);
            #1;
            @(negedge nsh_clk);
            chk("rst_inst", {22'd0, inst_code_a, inst_vld_a}, 0);
            chk("rst_res_a", {res_vld_a, res_ovf_a, err_sticky_a, res_cnt_a, res_err_a}, 0);
            chk("rst_sum_a", res_sum_a, 0);
            chk("rst_minmax_a", {code_min_a, code_max_a}, 0);
            chk("rst_res_b", {res_vld_b, res_ovf_b, err_sticky_b, res_cnt_b, res_err_b, inst_vld_b}, 0);
            @(posedge nsh_clk);
            #1;
        end
        rst = 1'b0;
        ref_tick = 1'b0;
        hist_code[0] = 0; hist_code[1] = 0;
        hist_vld[0]  = 0; hist_vld[1]  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        V54  = '{16'h0007, 16'h0008, 16'h001F, 16'hFFE0, 3'b001, 54, 1'b1};
        VBAD = '{16'h0005, 16'h0008, 16'h001F, 16'hFFE0, 3'b001, 0, 1'b0};
        tbl[0]  = V54;
        tbl[1]  = VBAD;
        tbl[2]  = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 3'b111, 259, 1'b1};
        tbl[3]  = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 3'b111, 0, 1'b0};
        tbl[4]  = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 3'b000, 0, 1'b1};
        tbl[5]  = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 3'b011, 258, 1'b1};
        tbl[6]  = '{16'h0007, 16'h0008, 16'h001F, 16'hFFE0, 3'b010, 0, 1'b0};
        tbl[7]  = '{16'h0007, 16'h0010, 16'h001F, 16'hFFE0, 3'b001, 0, 1'b0};
        tbl[8]  = '{16'h0007, 16'h0008, 16'h001F, 16'hFFE1, 3'b001, 0, 1'b0};
        tbl[9]  = '{16'h0007, 16'h0008, 16'h0005, 16'hFFFA, 3'b001, 0, 1'b0};
        tbl[10] = '{16'h0003, 16'h0004, 16'hFFFF, 16'h0000, 3'b111, 51, 1'b1};
        tbl[11] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 3'b000, 0, 1'b0};

        @(posedge nsh_clk);
        #1;
        mon_en = 1;
        do_reset(2);

        for (int w = 0; w < 4; w++) run_window(V54, 10, 0, 0);
        sticky_chk = 0;
        run_window(V54, 10, 3, 2);
        sticky_chk = 1;
        run_window(V54, 10, 0, 1);

        for (int i = 0; i < 12; i++) step(tbl[i], i == 0);
        sticky_chk = 1;
        run_window(tbl[2], 6, 0, 0);

        run_window(V54, 20, 0, 0);
        run_window(V54, 20, 0, 0);
        run_window(V54, 1, 0, 0);
        run_window(V54, 1, 0, 0);
        run_window(V54, 20, 0, 20);
        run_window(V54, 10, 0, 0);

        run_window(V54, 4, 0, 0);
        do_reset(2);
        for (int w = 0; w < 3; w++) run_window(V54, 10, 0, 0);
        step(V54, 1'b1);
        for (int i = 0; i < 6; i++) step(V54, 1'b0);

        chk("scoreboard_drain", sbq0.size() + sbq1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
